// File: rtl/alu_reservation_station_if.sv
// Dispatch, wakeup and issue bundle between the ALU reservation station and its neighbours.
interface alu_reservation_station_if #(
    parameter int unsigned ENTRY_NUM     = 4,
    parameter int unsigned DATA_LEN      = 32,
    parameter int unsigned ALU_OP_WIDTH  = 4,
    parameter int unsigned RRF_TAG_WIDTH = 6
);
    localparam int unsigned CNT_W = $clog2(ENTRY_NUM) + 1;

    logic                     flush_i;
    logic                     dispatch_valid_i;
    logic [ALU_OP_WIDTH-1:0]  dispatch_alu_op_i;
    logic [DATA_LEN-1:0]      dispatch_src1_i;
    logic                     dispatch_src1_ready_i;
    logic [DATA_LEN-1:0]      dispatch_src2_i;
    logic                     dispatch_src2_ready_i;
    logic [RRF_TAG_WIDTH-1:0] dispatch_rrf_tag_i;
    logic                     dispatch_if_write_rrf_i;
    logic                     wakeup_valid_i;
    logic [RRF_TAG_WIDTH-1:0] wakeup_tag_i;
    logic [DATA_LEN-1:0]      wakeup_data_i;
    logic                     issue_stall_i;

    logic                     full_o;
    logic [CNT_W-1:0]         free_count_o;
    logic                     issue_o;
    logic [ALU_OP_WIDTH-1:0]  alu_op_o;
    logic [DATA_LEN-1:0]      src1_o;
    logic [DATA_LEN-1:0]      src2_o;
    logic [RRF_TAG_WIDTH-1:0] rrf_tag_o;
    logic                     if_write_rrf_o;

    modport master (
        output flush_i, dispatch_valid_i, dispatch_alu_op_i, dispatch_src1_i,
               dispatch_src1_ready_i, dispatch_src2_i, dispatch_src2_ready_i,
               dispatch_rrf_tag_i, dispatch_if_write_rrf_i, wakeup_valid_i,
               wakeup_tag_i, wakeup_data_i, issue_stall_i,
        input  full_o, free_count_o, issue_o, alu_op_o, src1_o, src2_o,
               rrf_tag_o, if_write_rrf_o
    );

    modport slave (
        input  flush_i, dispatch_valid_i, dispatch_alu_op_i, dispatch_src1_i,
               dispatch_src1_ready_i, dispatch_src2_i, dispatch_src2_ready_i,
               dispatch_rrf_tag_i, dispatch_if_write_rrf_i, wakeup_valid_i,
               wakeup_tag_i, wakeup_data_i, issue_stall_i,
        output full_o, free_count_o, issue_o, alu_op_o, src1_o, src2_o,
               rrf_tag_o, if_write_rrf_o
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Out-of-order issue buffer for the ALU pipe: holds dispatched ops until both
// operands are captured, then issues the lowest-index ready entry.
module alu_reservation_station #(
    parameter int unsigned ENTRY_NUM     = 4,
    parameter int unsigned DATA_LEN      = 32,
    parameter int unsigned ALU_OP_WIDTH  = 4,
    parameter int unsigned RRF_TAG_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    alu_reservation_station_if.slave rs
);
    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ENTRY_NUM-1:0]     busy_q;
    logic [ENTRY_NUM-1:0]     src1_rdy_q;
    logic [ENTRY_NUM-1:0]     src2_rdy_q;
    logic [ENTRY_NUM-1:0]     wr_rrf_q;
    logic [ALU_OP_WIDTH-1:0]  alu_op_q  [ENTRY_NUM];
    logic [DATA_LEN-1:0]      src1_q    [ENTRY_NUM];
    logic [DATA_LEN-1:0]      src2_q    [ENTRY_NUM];
    logic [RRF_TAG_WIDTH-1:0] rrf_tag_q [ENTRY_NUM];

    logic [ENTRY_NUM-1:0]     wake1;
    logic [ENTRY_NUM-1:0]     wake2;
    logic [ENTRY_NUM-1:0]     eligible;
    logic                     disp_hit1;
    logic                     disp_hit2;
    logic                     disp_en;
    logic [IDX_W-1:0]         alloc_idx;
    logic                     alloc_ok;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_ok;
    logic                     issue_en;
    logic [CNT_W-1:0]         free_cnt;

    // Tag match of the broadcast against stored and incoming sources.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            wake1[i] = rs.wakeup_valid_i && !src1_rdy_q[i] &&
                       (src1_q[i][RRF_TAG_WIDTH-1:0] == rs.wakeup_tag_i);
            wake2[i] = rs.wakeup_valid_i && !src2_rdy_q[i] &&
                       (src2_q[i][RRF_TAG_WIDTH-1:0] == rs.wakeup_tag_i);
        end
        disp_hit1 = rs.wakeup_valid_i && !rs.dispatch_src1_ready_i &&
                    (rs.dispatch_src1_i[RRF_TAG_WIDTH-1:0] == rs.wakeup_tag_i);
        disp_hit2 = rs.wakeup_valid_i && !rs.dispatch_src2_ready_i &&
                    (rs.dispatch_src2_i[RRF_TAG_WIDTH-1:0] == rs.wakeup_tag_i);
    end

    // Lowest free entry for allocation, lowest ready entry for issue, free count.
    always_comb begin
        alloc_idx = '0;
        alloc_ok  = 1'b0;
        sel_idx   = '0;
        sel_ok    = 1'b0;
        free_cnt  = '0;
        eligible  = busy_q & src1_rdy_q & src2_rdy_q;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            if (eligible[i]) begin
                sel_ok  = 1'b1;
                sel_idx = IDX_W'(i);
            end
            free_cnt = free_cnt + CNT_W'(!busy_q[i]);
        end
        disp_en  = rs.dispatch_valid_i && alloc_ok && !rs.flush_i;
        issue_en = sel_ok && !rs.issue_stall_i && !rs.flush_i;
    end

    // Entry storage: flush kill, wakeup capture, issue release, dispatch write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q     <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            wr_rrf_q   <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                alu_op_q[i]  <= '0;
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
                rrf_tag_q[i] <= '0;
            end
        end else if (rs.flush_i) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (busy_q[i] && wake1[i]) begin
                    src1_q[i]     <= rs.wakeup_data_i;
                    src1_rdy_q[i] <= 1'b1;
                end
                if (busy_q[i] && wake2[i]) begin
                    src2_q[i]     <= rs.wakeup_data_i;
                    src2_rdy_q[i] <= 1'b1;
                end
                if (issue_en && (sel_idx == IDX_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
                // Allocation only targets a non-busy entry, so it never collides with the above.
                if (disp_en && (alloc_idx == IDX_W'(i))) begin
                    busy_q[i]     <= 1'b1;
                    alu_op_q[i]   <= rs.dispatch_alu_op_i;
                    rrf_tag_q[i]  <= rs.dispatch_rrf_tag_i;
                    wr_rrf_q[i]   <= rs.dispatch_if_write_rrf_i;
                    src1_q[i]     <= disp_hit1 ? rs.wakeup_data_i : rs.dispatch_src1_i;
                    src1_rdy_q[i] <= rs.dispatch_src1_ready_i || disp_hit1;
                    src2_q[i]     <= disp_hit2 ? rs.wakeup_data_i : rs.dispatch_src2_i;
                    src2_rdy_q[i] <= rs.dispatch_src2_ready_i || disp_hit2;
                end
            end
        end
    end

    // Issue bundle and occupancy status; data is zeroed when nothing issues.
    always_comb begin
        rs.full_o         = &busy_q;
        rs.free_count_o   = free_cnt;
        rs.issue_o        = issue_en;
        rs.alu_op_o       = '0;
        rs.src1_o         = '0;
        rs.src2_o         = '0;
        rs.rrf_tag_o      = '0;
        rs.if_write_rrf_o = 1'b0;
        if (issue_en) begin
            rs.alu_op_o       = alu_op_q[sel_idx];
            rs.src1_o         = src1_q[sel_idx];
            rs.src2_o         = src2_q[sel_idx];
            rs.rrf_tag_o      = rrf_tag_q[sel_idx];
            rs.if_write_rrf_o = wr_rrf_q[sel_idx];
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed-vector bench for the ALU reservation station.
module tb_alu_reservation_station;
    logic clk_i;
    logic reset_i;
    int   tests;
    int   fails;

    alu_reservation_station_if #(
        .ENTRY_NUM(4), .DATA_LEN(32), .ALU_OP_WIDTH(4), .RRF_TAG_WIDTH(6)
    ) bus ();

    alu_reservation_station #(
        .ENTRY_NUM(4), .DATA_LEN(32), .ALU_OP_WIDTH(4), .RRF_TAG_WIDTH(6)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .rs      (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive all inputs inactive.
    task automatic idle();
        bus.flush_i                 = 1'b0;
        bus.dispatch_valid_i        = 1'b0;
        bus.dispatch_alu_op_i       = '0;
        bus.dispatch_src1_i         = '0;
        bus.dispatch_src1_ready_i   = 1'b0;
        bus.dispatch_src2_i         = '0;
        bus.dispatch_src2_ready_i   = 1'b0;
        bus.dispatch_rrf_tag_i      = '0;
        bus.dispatch_if_write_rrf_i = 1'b0;
        bus.wakeup_valid_i          = 1'b0;
        bus.wakeup_tag_i            = '0;
        bus.wakeup_data_i           = '0;
        bus.issue_stall_i           = 1'b0;
    endtask

    // Present one dispatch request for the next edge.
    task automatic dispatch(input logic [3:0] op, input logic [31:0] s1, input logic r1,
                            input logic [31:0] s2, input logic r2, input logic [5:0] tag,
                            input logic wr);
        bus.dispatch_valid_i        = 1'b1;
        bus.dispatch_alu_op_i       = op;
        bus.dispatch_src1_i         = s1;
        bus.dispatch_src1_ready_i   = r1;
        bus.dispatch_src2_i         = s2;
        bus.dispatch_src2_ready_i   = r2;
        bus.dispatch_rrf_tag_i      = tag;
        bus.dispatch_if_write_rrf_i = wr;
    endtask

    // Present one wakeup broadcast for the next edge.
    task automatic wake(input logic [5:0] tag, input logic [31:0] data);
        bus.wakeup_valid_i = 1'b1;
        bus.wakeup_tag_i   = tag;
        bus.wakeup_data_i  = data;
    endtask

    // Advance to the next falling edge and clear inputs.
    task automatic cyc();
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        idle();
        repeat (2) @(negedge clk_i);
        #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL reset_issue: got %0h want 0", bus.issue_o); end
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL reset_free: got %0d want 4", bus.free_count_o); end
        tests++; if (bus.full_o !== 1'b0) begin fails++; $display("FAIL reset_full: got %0h want 0", bus.full_o); end
        tests++; if (bus.src1_o !== 32'h0) begin fails++; $display("FAIL reset_src1: got %0h want 0", bus.src1_o); end
        reset_i = 1'b0;
    endtask

    task automatic test_basic_issue();
        cyc(); dispatch(4'd3, 32'h10, 1'b1, 32'h20, 1'b1, 6'd7, 1'b1); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL basic_early: got %0h want 0", bus.issue_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1) begin fails++; $display("FAIL basic_issue: got %0h want 1", bus.issue_o); end
        tests++; if (bus.alu_op_o !== 4'd3) begin fails++; $display("FAIL basic_op: got %0h want 3", bus.alu_op_o); end
        tests++; if (bus.src1_o !== 32'h10) begin fails++; $display("FAIL basic_src1: got %0h want 10", bus.src1_o); end
        tests++; if (bus.src2_o !== 32'h20) begin fails++; $display("FAIL basic_src2: got %0h want 20", bus.src2_o); end
        tests++; if (bus.rrf_tag_o !== 6'd7) begin fails++; $display("FAIL basic_tag: got %0d want 7", bus.rrf_tag_o); end
        tests++; if (bus.if_write_rrf_o !== 1'b1) begin fails++; $display("FAIL basic_wr: got %0h want 1", bus.if_write_rrf_o); end
        tests++; if (bus.free_count_o !== 3'd3) begin fails++; $display("FAIL basic_free_busy: got %0d want 3", bus.free_count_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL basic_done: got %0h want 0", bus.issue_o); end
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL basic_free: got %0d want 4", bus.free_count_o); end
    endtask

    task automatic test_wakeup();
        cyc(); dispatch(4'd5, 32'd5, 1'b0, 32'h22, 1'b1, 6'd9, 1'b0);
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL wake_wait: got %0h want 0", bus.issue_o); end
        cyc(); wake(6'd5, 32'hABCD); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL wake_nocomb: got %0h want 0", bus.issue_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1) begin fails++; $display("FAIL wake_issue: got %0h want 1", bus.issue_o); end
        tests++; if (bus.src1_o !== 32'hABCD) begin fails++; $display("FAIL wake_src1: got %0h want abcd", bus.src1_o); end
        tests++; if (bus.src2_o !== 32'h22) begin fails++; $display("FAIL wake_src2: got %0h want 22", bus.src2_o); end
        tests++; if (bus.if_write_rrf_o !== 1'b0) begin fails++; $display("FAIL wake_wr: got %0h want 0", bus.if_write_rrf_o); end
        cyc(); #1;
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL wake_free: got %0d want 4", bus.free_count_o); end
        // Same-cycle dispatch and broadcast of the awaited tag.
        cyc(); dispatch(4'd6, 32'd5, 1'b0, 32'h5, 1'b1, 6'd1, 1'b1); wake(6'd5, 32'h1234);
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1) begin fails++; $display("FAIL bypass_issue: got %0h want 1", bus.issue_o); end
        tests++; if (bus.src1_o !== 32'h1234) begin fails++; $display("FAIL bypass_src1: got %0h want 1234", bus.src1_o); end
        // Tag 0 on both sources, woken together.
        cyc(); dispatch(4'd7, 32'd0, 1'b0, 32'd0, 1'b0, 6'd2, 1'b0); #1;
        cyc(); wake(6'd0, 32'h77); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL tag0_wait: got %0h want 0", bus.issue_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1) begin fails++; $display("FAIL tag0_issue: got %0h want 1", bus.issue_o); end
        tests++; if (bus.src1_o !== 32'h77) begin fails++; $display("FAIL tag0_src1: got %0h want 77", bus.src1_o); end
        tests++; if (bus.src2_o !== 32'h77) begin fails++; $display("FAIL tag0_src2: got %0h want 77", bus.src2_o); end
        tests++; if (bus.alu_op_o !== 4'd7) begin fails++; $display("FAIL tag0_op: got %0h want 7", bus.alu_op_o); end
        cyc();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            cyc(); dispatch(4'(i + 1), 32'(20 + i), 1'b0, 32'(32'h100 + i), 1'b1, 6'(30 + i), 1'b1);
        end
        cyc(); dispatch(4'd15, 32'h1, 1'b1, 32'h2, 1'b1, 6'd40, 1'b1); #1;
        tests++; if (bus.full_o !== 1'b1) begin fails++; $display("FAIL full_flag: got %0h want 1", bus.full_o); end
        tests++; if (bus.free_count_o !== 3'd0) begin fails++; $display("FAIL full_free: got %0d want 0", bus.free_count_o); end
        cyc(); wake(6'd20, 32'h2000); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL full_noissue: got %0h want 0", bus.issue_o); end
        tests++; if (bus.full_o !== 1'b1) begin fails++; $display("FAIL full_drop: got %0h want 1", bus.full_o); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i < 3) wake(6'(21 + i), 32'(32'h2001 + i));
            #1;
            tests++;
            if (bus.issue_o !== 1'b1 || bus.alu_op_o !== 4'(i + 1) || bus.src1_o !== 32'(32'h2000 + i) ||
                bus.src2_o !== 32'(32'h100 + i) || bus.rrf_tag_o !== 6'(30 + i)) begin
                fails++;
                $display("FAIL full_order%0d: got issue=%0h op=%0h src1=%0h src2=%0h tag=%0d want issue=1 op=%0h src1=%0h src2=%0h tag=%0d",
                         i, bus.issue_o, bus.alu_op_o, bus.src1_o, bus.src2_o, bus.rrf_tag_o,
                         i + 1, 32'h2000 + i, 32'h100 + i, 30 + i);
            end
            tests++; if (bus.free_count_o !== 3'(i)) begin fails++; $display("FAIL full_drain%0d: got %0d want %0d", i, bus.free_count_o, i); end
        end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL full_5th_dropped: got %0h want 0", bus.issue_o); end
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL full_empty: got %0d want 4", bus.free_count_o); end
        tests++; if (bus.full_o !== 1'b0) begin fails++; $display("FAIL full_clear: got %0h want 0", bus.full_o); end
    endtask

    task automatic test_stall();
        cyc(); dispatch(4'd9, 32'h55, 1'b1, 32'h66, 1'b1, 6'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.issue_stall_i = 1'b1;
            if (i == 0) dispatch(4'd10, 32'h1, 1'b1, 32'h2, 1'b1, 6'd12, 1'b0);
            #1;
            tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL stall_issue%0d: got %0h want 0", i, bus.issue_o); end
            tests++; if (bus.src1_o !== 32'h0 || bus.alu_op_o !== 4'h0) begin fails++; $display("FAIL stall_data%0d: got src1=%0h op=%0h want 0", i, bus.src1_o, bus.alu_op_o); end
            tests++; if (bus.free_count_o !== ((i == 0) ? 3'd3 : 3'd2)) begin fails++; $display("FAIL stall_free%0d: got %0d want %0d", i, bus.free_count_o, (i == 0) ? 3 : 2); end
        end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1 || bus.alu_op_o !== 4'd9 || bus.src1_o !== 32'h55) begin fails++; $display("FAIL stall_release: got issue=%0h op=%0h src1=%0h want 1 9 55", bus.issue_o, bus.alu_op_o, bus.src1_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1 || bus.alu_op_o !== 4'd10 || bus.src2_o !== 32'h2) begin fails++; $display("FAIL stall_second: got issue=%0h op=%0h src2=%0h want 1 a 2", bus.issue_o, bus.alu_op_o, bus.src2_o); end
        tests++; if (bus.free_count_o !== 3'd3) begin fails++; $display("FAIL stall_free_mid: got %0d want 3", bus.free_count_o); end
        cyc(); #1;
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL stall_free_end: got %0d want 4", bus.free_count_o); end
    endtask

    task automatic test_flush();
        cyc(); dispatch(4'd12, 32'd3, 1'b0, 32'h4, 1'b1, 6'd13, 1'b1);
        cyc(); dispatch(4'd11, 32'hA, 1'b1, 32'hB, 1'b1, 6'd14, 1'b1);
        cyc(); bus.flush_i = 1'b1; dispatch(4'd13, 32'h1, 1'b1, 32'h1, 1'b1, 6'd15, 1'b1); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL flush_issue: got %0h want 0", bus.issue_o); end
        tests++; if (bus.free_count_o !== 3'd2) begin fails++; $display("FAIL flush_pre_free: got %0d want 2", bus.free_count_o); end
        cyc(); wake(6'd3, 32'h99); #1;
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL flush_free: got %0d want 4", bus.free_count_o); end
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL flush_after: got %0h want 0", bus.issue_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL flush_dead_wake: got %0h want 0", bus.issue_o); end
    endtask

    task automatic test_back_to_back();
        cyc(); dispatch(4'd1, 32'hA1, 1'b1, 32'hA2, 1'b1, 6'd21, 1'b0);
        cyc(); dispatch(4'd2, 32'hB1, 1'b1, 32'hB2, 1'b1, 6'd22, 1'b1); #1;
        tests++; if (bus.issue_o !== 1'b1 || bus.src1_o !== 32'hA1) begin fails++; $display("FAIL b2b_first: got issue=%0h src1=%0h want 1 a1", bus.issue_o, bus.src1_o); end
        tests++; if (bus.free_count_o !== 3'd3) begin fails++; $display("FAIL b2b_free1: got %0d want 3", bus.free_count_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1 || bus.src1_o !== 32'hB1 || bus.rrf_tag_o !== 6'd22) begin fails++; $display("FAIL b2b_second: got issue=%0h src1=%0h tag=%0d want 1 b1 22", bus.issue_o, bus.src1_o, bus.rrf_tag_o); end
        tests++; if (bus.free_count_o !== 3'd3) begin fails++; $display("FAIL b2b_free2: got %0d want 3", bus.free_count_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b0 || bus.free_count_o !== 3'd4) begin fails++; $display("FAIL b2b_end: got issue=%0h free=%0d want 0 4", bus.issue_o, bus.free_count_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.issue_stall_i = 1'b1;
            dispatch(4'(i + 4), 32'(i), 1'b1, 32'(i), 1'b1, 6'(i), 1'b1);
        end
        cyc(); bus.issue_stall_i = 1'b1; #1;
        tests++; if (bus.free_count_o !== 3'd1) begin fails++; $display("FAIL rmid_busy: got %0d want 1", bus.free_count_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b1) begin fails++; $display("FAIL rmid_pre: got %0h want 1", bus.issue_o); end
        reset_i = 1'b1; #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL rmid_async_issue: got %0h want 0", bus.issue_o); end
        tests++; if (bus.free_count_o !== 3'd4) begin fails++; $display("FAIL rmid_async_free: got %0d want 4", bus.free_count_o); end
        tests++; if (bus.src1_o !== 32'h0) begin fails++; $display("FAIL rmid_async_data: got %0h want 0", bus.src1_o); end
        cyc(); reset_i = 1'b0; #1;
        tests++; if (bus.full_o !== 1'b0 || bus.free_count_o !== 3'd4) begin fails++; $display("FAIL rmid_release: got full=%0h free=%0d want 0 4", bus.full_o, bus.free_count_o); end
        cyc(); #1;
        tests++; if (bus.issue_o !== 1'b0) begin fails++; $display("FAIL rmid_quiet: got %0h want 0", bus.issue_o); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
